// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, pointer encoding and request struct for the write arbiter
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    PREF_A = 1'b0,
    PREF_B = 1'b1
  } rr_ptr_t;

  typedef struct packed {
    logic [ADDR_W-1:0] reg_idx;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/wr_req_fifo.sv
// rtl/wr_req_fifo.sv - 2-entry request FIFO exposing per-slot valid/reg for the busy scoreboard
module wr_req_fifo
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wr_req_t               push_req,
  input  logic                  pop,
  output wr_req_t               head,
  output logic [1:0]            count,
  output logic [1:0]            entry_valid,
  output logic [2*ADDR_W-1:0]   entry_regs
);

  wr_req_t    mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] vld;
  logic       do_push;
  logic       do_pop;

  // Slot occupancy guards the pointers even if a caller ignores full/empty.
  assign do_push = push && !vld[wr_ptr];
  assign do_pop  = pop && vld[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      vld    <= 2'b00;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_req;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      for (int i = 0; i < 2; i++) begin
        if (do_push && (wr_ptr == 1'(i))) begin
          vld[i] <= 1'b1;
        end else if (do_pop && (rd_ptr == 1'(i))) begin
          vld[i] <= 1'b0;
        end
      end
    end
  end

  assign head        = mem[rd_ptr];
  assign count       = {vld[0] & vld[1], vld[0] ^ vld[1]};
  assign entry_valid = vld;
  assign entry_regs  = {mem[1].reg_idx, mem[0].reg_idx};

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the register file write port between A and B
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_reg,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_reg,
  input  logic [DATA_W-1:0]   b_data,
  output logic                rf_write_en,
  output logic [ADDR_W-1:0]   rf_write_reg,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [2:0]          pend_cnt
);

  wr_req_t               a_head;
  wr_req_t               b_head;
  wr_req_t               grant_req;
  logic [1:0]            a_count;
  logic [1:0]            b_count;
  logic [1:0]            a_vld;
  logic [1:0]            b_vld;
  logic [2*ADDR_W-1:0]   a_regs;
  logic [2*ADDR_W-1:0]   b_regs;
  logic                  a_push;
  logic                  b_push;
  logic                  a_nonempty;
  logic                  b_nonempty;
  logic                  grant_a;
  logic                  grant_b;
  rr_ptr_t               ptr;
  logic [NUM_REGS-1:0]   busy_next;

  assign a_ready = !reset && (a_count != 2'd2);
  assign b_ready = !reset && (b_count != 2'd2);
  assign a_push  = a_valid && a_ready;
  assign b_push  = b_valid && b_ready;

  assign a_nonempty = (a_count != 2'd0);
  assign b_nonempty = (b_count != 2'd0);
  assign grant_a    = a_nonempty && (!b_nonempty || (ptr == PREF_A));
  assign grant_b    = b_nonempty && !grant_a;
  assign grant_req  = grant_a ? a_head : b_head;

  wr_req_fifo u_fifo_a (
    .clk         (clk),
    .reset       (reset),
    .push        (a_push),
    .push_req    ({a_reg, a_data}),
    .pop         (grant_a),
    .head        (a_head),
    .count       (a_count),
    .entry_valid (a_vld),
    .entry_regs  (a_regs)
  );

  wr_req_fifo u_fifo_b (
    .clk         (clk),
    .reset       (reset),
    .push        (b_push),
    .push_req    ({b_reg, b_data}),
    .pop         (grant_b),
    .head        (b_head),
    .count       (b_count),
    .entry_valid (b_vld),
    .entry_regs  (b_regs)
  );

  // A popped entry moves into the output register, so every currently buffered
  // entry stays busy next cycle; only fresh pushes add to that set.
  always_comb begin
    busy_next = '0;
    for (int i = 0; i < 2; i++) begin
      if (a_vld[i]) busy_next[a_regs[i*ADDR_W +: ADDR_W]] = 1'b1;
      if (b_vld[i]) busy_next[b_regs[i*ADDR_W +: ADDR_W]] = 1'b1;
    end
    if (a_push) busy_next[a_reg] = 1'b1;
    if (b_push) busy_next[b_reg] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr           <= PREF_A;
      rf_write_en   <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      busy_mask     <= '0;
    end else begin
      if (grant_a || grant_b) begin
        rf_write_reg  <= grant_req.reg_idx;
        rf_write_data <= grant_req.data;
        rf_write_en   <= (grant_req.reg_idx != '0);
      end else begin
        rf_write_en <= 1'b0;
      end
      if (a_nonempty && b_nonempty) begin
        ptr <= (ptr == PREF_A) ? PREF_B : PREF_A;
      end
      busy_mask <= busy_next;
    end
  end

  assign pend_cnt = {1'b0, a_count} + {1'b0, b_count};

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                a_valid;
  logic                a_ready;
  logic [ADDR_W-1:0]   a_reg;
  logic [DATA_W-1:0]   a_data;
  logic                b_valid;
  logic                b_ready;
  logic [ADDR_W-1:0]   b_reg;
  logic [DATA_W-1:0]   b_data;
  logic                rf_write_en;
  logic [ADDR_W-1:0]   rf_write_reg;
  logic [DATA_W-1:0]   rf_write_data;
  logic [NUM_REGS-1:0] busy_mask;
  logic [2:0]          pend_cnt;

  regfile_write_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_reg         (a_reg),
    .a_data        (a_data),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .b_reg         (b_reg),
    .b_data        (b_data),
    .rf_write_en   (rf_write_en),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .busy_mask     (busy_mask),
    .pend_cnt      (pend_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    a_valid = v;
    a_reg   = r;
    a_data  = d;
  endtask

  task automatic drive_b(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    b_valid = v;
    b_reg   = r;
    b_data  = d;
  endtask

  // Monitor: every issued write must match the head of the expected queue.
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] exp;
    if (!reset && rf_write_en) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got reg %0d data 0x%0h, expected no write", rf_write_reg, rf_write_data);
      end else begin
        exp = exp_q.pop_front();
        check("issued_write", 64'({rf_write_reg, rf_write_data}), 64'(exp));
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    #1;
    check("ready_in_reset", {a_ready, b_ready}, 2'b00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_ready", {a_ready, b_ready}, 2'b11);
    check("rst_en", rf_write_en, 0);
    check("rst_busy", busy_mask, 0);
    check("rst_pend", pend_cnt, 0);

    // Single write to r5
    expect_write(5'd5, 32'hDEADBEEF);
    drive_a(1'b1, 5'd5, 32'hDEADBEEF);
    cyc();
    drive_a(1'b0, '0, '0);
    check("single_busy_n", busy_mask, 32'h0000_0020);
    check("single_pend_n", pend_cnt, 1);
    cyc();
    check("single_en_n1", rf_write_en, 1);
    check("single_reg_n1", rf_write_reg, 5);
    check("single_busy_n1", busy_mask, 32'h0000_0020);
    check("single_pend_n1", pend_cnt, 0);
    cyc();
    check("single_busy_n2", busy_mask, 0);
    check("single_en_n2", rf_write_en, 0);

    // Contention: A r1,r2 and B r3,r4 -> issue r1, r3, r2, r4
    expect_write(5'd1, 32'h11);
    expect_write(5'd3, 32'h33);
    expect_write(5'd2, 32'h22);
    expect_write(5'd4, 32'h44);
    drive_a(1'b1, 5'd1, 32'h11);
    drive_b(1'b1, 5'd3, 32'h33);
    cyc();
    check("cont_pend_0", pend_cnt, 2);
    check("cont_busy_0", busy_mask, 32'h0000_000A);
    check("cont_ready_0", {a_ready, b_ready}, 2'b11);
    drive_a(1'b1, 5'd2, 32'h22);
    drive_b(1'b1, 5'd4, 32'h44);
    cyc();
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    check("cont_pend_1", pend_cnt, 3);
    check("cont_ready_1", {a_ready, b_ready}, 2'b10);
    check("cont_busy_1", busy_mask, 32'h0000_001E);
    check("cont_reg_1", rf_write_reg, 1);
    cyc();
    check("cont_reg_2", rf_write_reg, 3);
    check("cont_pend_2", pend_cnt, 2);
    check("cont_ready_2", {a_ready, b_ready}, 2'b11);
    cyc();
    check("cont_reg_3", rf_write_reg, 2);
    check("cont_pend_3", pend_cnt, 1);
    cyc();
    check("cont_reg_4", rf_write_reg, 4);
    check("cont_pend_4", pend_cnt, 0);
    cyc();
    check("cont_idle", rf_write_en, 0);

    // r0 write is consumed but never issued
    drive_b(1'b1, 5'd0, 32'hFFFFFFFF);
    cyc();
    drive_b(1'b0, '0, '0);
    check("r0_pend_n", pend_cnt, 1);
    check("r0_busy_n", busy_mask, 0);
    check("r0_en_n", rf_write_en, 0);
    cyc();
    check("r0_pend_n1", pend_cnt, 0);
    check("r0_en_n1", rf_write_en, 0);
    check("r0_busy_n1", busy_mask, 0);

    // Back-pressure: pointer favours B here, so A fills and its third push stalls
    expect_write(5'd10, 32'hA0);
    expect_write(5'd7, 32'd1);
    expect_write(5'd11, 32'hB0);
    expect_write(5'd7, 32'd2);
    expect_write(5'd7, 32'd3);
    drive_a(1'b1, 5'd7, 32'd1);
    drive_b(1'b1, 5'd10, 32'hA0);
    cyc();
    check("bp_pend_1", pend_cnt, 2);
    drive_a(1'b1, 5'd7, 32'd2);
    drive_b(1'b1, 5'd11, 32'hB0);
    cyc();
    check("bp_pend_2", pend_cnt, 3);
    check("bp_a_full", a_ready, 0);
    check("bp_busy_2", busy_mask, 32'h0000_0C80);
    check("bp_reg_2", rf_write_reg, 10);
    drive_a(1'b1, 5'd7, 32'd3);
    drive_b(1'b0, '0, '0);
    cyc();
    check("bp_pend_3", pend_cnt, 2);
    check("bp_a_free", a_ready, 1);
    check("bp_data_3", rf_write_data, 1);
    cyc();
    drive_a(1'b0, '0, '0);
    check("bp_pend_4", pend_cnt, 2);
    check("bp_a_full_4", a_ready, 0);
    check("bp_reg_4", rf_write_reg, 11);
    cyc();
    check("bp_pend_5", pend_cnt, 1);
    cyc();
    check("bp_pend_6", pend_cnt, 0);
    check("bp_data_6", rf_write_data, 3);
    cyc();
    check("bp_idle", rf_write_en, 0);

    // Async reset with three entries pending and a write on the port
    expect_write(5'd12, 32'hC0);
    drive_a(1'b1, 5'd12, 32'hC0);
    drive_b(1'b1, 5'd13, 32'hD0);
    cyc();
    drive_a(1'b1, 5'd14, 32'hE0);
    drive_b(1'b1, 5'd15, 32'hF0);
    cyc();
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    check("ar_en_pre", rf_write_en, 1);
    check("ar_pend_pre", pend_cnt, 3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("ar_en", rf_write_en, 0);
    check("ar_reg", rf_write_reg, 0);
    check("ar_data", rf_write_data, 0);
    check("ar_busy", busy_mask, 0);
    check("ar_pend", pend_cnt, 0);
    check("ar_ready", {a_ready, b_ready}, 2'b00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) cyc();
    check("ar_pend_after", pend_cnt, 0);
    check("ar_en_after", rf_write_en, 0);

    check("scoreboard_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: A (ALU result) and B (memory load). Each requester gets a 2-entry request buffer with a valid/ready handshake. A round-robin scheduler issues at most one register write per cycle. A busy scoreboard tells the issue logic which registers still have writes in flight. The block sits between the writeback stage and the register file's write_data / write_reg / regWrite inputs.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register index width
NUM_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
a_valid  input  1  requester A has a write
a_ready  output  1  A buffer can accept
a_reg  input  ADDR_W  A destination register
a_data  input  DATA_W  A write data
b_valid  input  1  requester B has a write
b_ready  output  1  B buffer can accept
b_reg  input  ADDR_W  B destination register
b_data  input  DATA_W  B write data
rf_write_en  output  1  drives register file regWrite
rf_write_reg  output  ADDR_W  drives register file write_reg
rf_write_data  output  DATA_W  drives register file write_data
busy_mask  output  NUM_REGS  bit r set while a write to r is buffered or being driven
pend_cnt  output  3  total buffered entries, 0..4

Behaviour:
- Reset (async assert, sync-safe deassert): both buffers empty; round-robin pointer favours A next; rf_write_en=0, rf_write_reg=0, rf_write_data=0, busy_mask=0, pend_cnt=0. a_ready and b_ready are forced 0 while reset is high.
- Handshake: a request is accepted on a rising edge where valid && ready. a_ready = (A count < 2) and b_ready = (B count < 2). These are pure functions of registered count, with no combinational path from a_valid/b_valid or from the pop.
  - A full buffer is not ready, even in a cycle where it will pop.
  - valid may drop without acceptance; no retention requirement on requesters.
- Buffers: 2-deep FIFO per requester, storing {reg, data}. Order within a requester is preserved.
- Scheduler, two-state pointer PREF_A / PREF_B:
  - If only one buffer is non-empty, grant it.
  - If both are non-empty, grant the preferred side, then flip the pointer to the other side.
  - The pointer changes only on a contested grant.
  - Grant pops the head at the same edge.
- Output register: on a grant edge, rf_write_reg/rf_write_data load the popped entry, and rf_write_en = 1 unless the popped reg == 0.
  - With no grant, rf_write_en = 0; reg/data hold their last values.
  - Writes to r0 are accepted and consumed but never issued.
- Latency: request accepted at edge N → earliest grant at edge N+1 → rf_write_en high during cycle N+1..N+2. Sustained throughput is one write per cycle total.
- busy_mask = OR of one-hot(reg) over every valid entry in both buffers, plus one-hot(rf_write_reg) while rf_write_en = 1.
  - Bit 0 is always 0.
  - Registered: reflects state after each edge.
- pend_cnt = A count + B count, registered.
- Same-register conflict: A and B targeting the same reg are not reordered across requesters; last issued wins. Ordering across requesters is the issue logic's responsibility, using busy_mask.
- Reset mid-operation: all buffered requests are discarded; rf_write_en drops immediately (asynchronous).

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS
  - the pointer encoding (PREF_A=0, PREF_B=1)
  - a packed request struct {reg, data}
- Sub-module wr_req_fifo: 2-entry FIFO with push, pop, head, count, and per-entry valid/reg outputs for the scoreboard. Instantiated twice.

Test Plan:
- Reset release → a_ready=b_ready=1, rf_write_en=0, busy_mask=0, pend_cnt=0.
- Single write: A pushes (reg=5, data=0xDEADBEEF) at edge N.
  - busy_mask[5]=1 after edge N.
  - rf_write_en=1, reg=5, data=0xDEADBEEF after edge N+1.
  - busy_mask=0 after edge N+2.
- Contention: A and B each push 2 entries in the same cycles (A: r1, r2; B: r3, r4) → issue order r1, r3, r2, r4 on consecutive cycles. a_ready=0 exactly while A count=2.
- Full back-pressure: hold a_valid=1 with r7 data 1,2,3 and stall B.
  - The third push waits until a pop frees a slot.
  - Data 1,2,3 are issued in order.
  - pend_cnt never exceeds 2 for A.
- r0 suppression: B writes reg=0 data=0xFFFFFFFF → accepted, pend_cnt pulses 1, rf_write_en stays 0, busy_mask[0]=0.
- Async reset mid-stream: assert reset with 3 entries pending and rf_write_en=1.
  - All outputs go to reset values without waiting for a clock edge.
  - After release, no stale write is ever issued.
